// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the byte-serial FPU command front end.
package fpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ISSUE,
    S_WAIT,
    S_SEND
  } seq_state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SQRT = 3'd4;

  // Status byte layout: {timeout, 2'b00, NV, DZ, OF, UF, NX}
  localparam int STS_TO_BIT    = 7;
  localparam int STS_FLAGS_LSB = 0;
  localparam int STS_FLAGS_W   = 5;

  typedef struct packed {
    logic       timeout;
    logic [1:0] rsvd;
    logic [4:0] flags;
  } status_t;

endpackage

// File: rtl/fpu_byte_serializer.sv
// Parallel-load shift-out of NB+1 bytes over a valid/ready byte interface.
module fpu_byte_serializer
  import fpu_seq_pkg::*;
#(
  parameter int NB = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [(NB+1)*8-1:0] load_data,
  output logic [7:0]          out_byte,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                last
);

  localparam int TW = (NB + 1) * 8;
  localparam int RW = $clog2(NB + 1);

  logic [TW-1:0] shreg;
  logic [RW-1:0] rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      rem       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      shreg     <= load_data;
      rem       <= RW'(NB);
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      if (rem == '0) begin
        out_valid <= 1'b0;
        shreg     <= '0;
      end else begin
        shreg <= {shreg[TW-9:0], 8'h00};
        rem   <= rem - 1'b1;
      end
    end
  end

  assign out_byte = shreg[TW-1 -: 8];
  assign last     = (rem == '0);

endmodule

// File: rtl/fpu_op_sequencer.sv
// Byte-serial command front end: gathers opcode + operands, starts the FPU,
// waits for done under a timeout, then streams status + result back out.
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int OPC_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OPC_W-1:0]  fpu_op,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  output logic              fpu_start,
  input  logic              fpu_done,
  input  logic [DATA_W-1:0] fpu_result,
  input  logic [4:0]        fpu_flags,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  seq_state_t        state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] res_q;
  logic [4:0]        flags_q;
  logic              ser_load;
  logic              ser_last;
  logic              acc;
  logic              last_idx;
  status_t           sts;

  assign in_ready = (state == S_IDLE) || (state == S_LOAD_A) || (state == S_LOAD_B);
  assign busy     = (state != S_IDLE);
  assign acc      = in_valid && in_ready;
  assign last_idx = (idx == IDX_W'(NB - 1));
  assign sts      = status_t'({timeout_err, 2'b00, flags_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      fpu_op      <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      fpu_start   <= 1'b0;
      idx         <= '0;
      cnt         <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      timeout_err <= 1'b0;
      ser_load    <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      ser_load  <= 1'b0;
      case (state)
        S_IDLE: if (acc) begin
          fpu_op      <= in_byte[OPC_W-1:0];
          timeout_err <= 1'b0;
          idx         <= '0;
          state       <= S_LOAD_A;
        end
        S_LOAD_A: if (acc) begin
          fpu_a <= DATA_W'({fpu_a, in_byte});
          if (last_idx) begin
            idx   <= '0;
            state <= S_LOAD_B;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_LOAD_B: if (acc) begin
          fpu_b <= DATA_W'({fpu_b, in_byte});
          if (last_idx) begin
            idx       <= '0;
            fpu_start <= 1'b1;
            state     <= S_ISSUE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        // done during ISSUE belongs to no request of ours and is dropped
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (fpu_done) begin
            res_q    <= fpu_result;
            flags_q  <= fpu_flags;
            ser_load <= 1'b1;
            state    <= S_SEND;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            res_q       <= '1;
            flags_q     <= '0;
            timeout_err <= 1'b1;
            ser_load    <= 1'b1;
            state       <= S_SEND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SEND: if (out_valid && out_ready && ser_last) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  fpu_byte_serializer #(.NB(NB)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_data ({sts, res_q}),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last      (ser_last)
  );

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Randomized self-checking bench for fpu_op_sequencer with a behavioural FPU stub.
module tb_fpu_op_sequencer;
  localparam int DATA_W = 16, OPC_W = 3, TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        in_byte = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OPC_W-1:0]  fpu_op;
  logic [DATA_W-1:0] fpu_a, fpu_b;
  logic              fpu_start;
  logic              fpu_done = 1'b0;
  logic [DATA_W-1:0] fpu_result = '0;
  logic [4:0]        fpu_flags = '0;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              timeout_err;

  always #5 clk = ~clk;

  fpu_op_sequencer #(.DATA_W(DATA_W), .OPC_W(OPC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_start(fpu_start),
    .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  int errors = 0, checks = 0;
  logic [7:0]        obs[$];
  logic [23:0]       obs_word;
  int                obs_lat, obs_starts, obs_unstable;
  logic              obs_start_ok, obs_busy_after, obs_rdy_after, obs_terr_first;
  logic [OPC_W-1:0]  obs_op;
  logic [DATA_W-1:0] obs_a, obs_b;

  // Reference: what the response stream must be for a done on WAIT cycle done_at (<0: never)
  function automatic logic [23:0] model_bytes(input int done_at, input logic [15:0] res,
                                              input logic [4:0] flg);
    if (done_at < 0 || done_at >= TIMEOUT) return {8'h80, 16'hFFFF};
    return {3'b000, flg, res};
  endfunction

  // Cycles from the start pulse to the first out_valid
  function automatic int model_lat(input int done_at);
    return ((done_at < 0 || done_at >= TIMEOUT) ? TIMEOUT - 1 : done_at) + 3;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int g, guard;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) begin in_valid = 1'b0; @(negedge clk); end
    in_valid = 1'b1; in_byte = b; guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) begin checks++; errors++; $display("FAIL in_ready_stuck got=0 want=1"); end
    @(negedge clk);
    in_valid = 1'b0; in_byte = 8'($urandom);
  endtask

  // Drives one full command, plays the FPU core and the output consumer, records observations.
  task automatic do_cmd(input logic [7:0] opb, input logic [15:0] a, input logic [15:0] b,
                        input int done_at, input bit issue_done, input logic [15:0] res,
                        input logic [4:0] flg, input int gap_max, input int stall, input int rst_at);
    logic [7:0] bytes [5];
    int t, stall_left;
    bit hold;
    logic [7:0] held;
    bytes = '{opb, a[15:8], a[7:0], b[15:8], b[7:0]};
    obs.delete(); obs_lat = -1; obs_starts = 0; obs_unstable = 0; obs_word = 'x;
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i], gap_max);
      if (i == 0) obs_terr_first = timeout_err;
    end
    obs_start_ok = fpu_start; obs_op = fpu_op; obs_a = fpu_a; obs_b = fpu_b;
    hold = 1'b0; held = '0; stall_left = stall; t = 0;
    while (obs.size() < 3 && t < 700) begin
      if (rst_at == t) begin
        reset = 1'b1; fpu_done = 1'b0; out_ready = 1'b0;
        return;
      end
      if (fpu_start) obs_starts++;
      fpu_done   = (issue_done && t == 0) || (done_at >= 0 && t == done_at + 1);
      fpu_result = (t == 0) ? ~res : res;
      fpu_flags  = (t == 0) ? ~flg : flg;
      if (out_valid) begin
        if (obs_lat < 0) obs_lat = t;
        if (hold && out_byte !== held) obs_unstable++;
        if (stall_left > 0) begin
          out_ready = 1'b0; hold = 1'b1; held = out_byte; stall_left--;
        end else begin
          out_ready = 1'b1; hold = 1'b0; obs.push_back(out_byte); stall_left = stall;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk); t++;
    end
    fpu_done = 1'b0; out_ready = 1'b0;
    if (obs.size() < 3) begin
      checks++; errors++;
      $display("FAIL response_timeout got=%0d bytes want=3", obs.size());
    end else begin
      obs_word = {obs[0], obs[1], obs[2]};
    end
    obs_busy_after = busy; obs_rdy_after = in_ready;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy, out_valid, fpu_start, timeout_err} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl got=%b want=10000",
                         {in_ready, busy, out_valid, fpu_start, timeout_err});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({fpu_op, fpu_a, fpu_b, out_byte} !== '0) begin
      errors++; $display("FAIL reset_data got=%h want=0", {fpu_op, fpu_a, fpu_b, out_byte});
    end
  endtask

  task automatic test_basic();
    do_cmd(8'h00, 16'h3C00, 16'h4000, 2, 0, 16'h4200, 5'h00, 0, 0, -1);
    checks++; if (obs_word !== 24'h004200) begin errors++; $display("FAIL basic_bytes got=%h want=004200", obs_word); end
    checks++; if (obs_starts !== 1 || obs_start_ok !== 1'b1) begin errors++; $display("FAIL basic_start got=%0d/%b want=1/1", obs_starts, obs_start_ok); end
    checks++; if ({obs_a, obs_b} !== 32'h3C004000) begin errors++; $display("FAIL basic_operands got=%h want=3c004000", {obs_a, obs_b}); end
    checks++; if (obs_lat !== model_lat(2)) begin errors++; $display("FAIL basic_latency got=%0d want=%0d", obs_lat, model_lat(2)); end
    checks++; if ({obs_busy_after, obs_rdy_after} !== 2'b01) begin errors++; $display("FAIL basic_idle_after got=%b want=01", {obs_busy_after, obs_rdy_after}); end
  endtask

  task automatic test_timeout();
    do_cmd(8'h02, 16'h1234, 16'h5678, -1, 0, 16'h0000, 5'h00, 0, 0, -1);
    checks++; if (obs_word !== model_bytes(-1, 16'h0, 5'h0)) begin errors++; $display("FAIL timeout_bytes got=%h want=80ffff", obs_word); end
    checks++; if (obs_lat !== TIMEOUT + 2) begin errors++; $display("FAIL timeout_latency got=%0d want=%0d", obs_lat, TIMEOUT + 2); end
    checks++; if (obs_starts !== 1) begin errors++; $display("FAIL timeout_start got=%0d want=1", obs_starts); end
    repeat (3) @(negedge clk);
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_sticky got=%b%b want=10", timeout_err, busy); end
  endtask

  task automatic test_late_done();
    do_cmd(8'h03, 16'hAAAA, 16'h5555, TIMEOUT - 1, 0, 16'h3C00, 5'h01, 0, 0, -1);
    checks++; if (obs_terr_first !== 1'b0) begin errors++; $display("FAIL late_terr_clear got=%b want=0", obs_terr_first); end
    checks++; if (obs_word !== 24'h013C00) begin errors++; $display("FAIL late_bytes got=%h want=013c00", obs_word); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL late_terr got=%b want=0", timeout_err); end
    checks++; if (obs_lat !== model_lat(TIMEOUT - 1)) begin errors++; $display("FAIL late_latency got=%0d want=%0d", obs_lat, model_lat(TIMEOUT - 1)); end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 2; r++) begin
      do_cmd(8'h00, 16'h3C00, 16'h4000, 2, 0, 16'h4200, 5'h00, 3, 5, -1);
      checks++; if (obs_word !== 24'h004200) begin errors++; $display("FAIL bp_bytes got=%h want=004200", obs_word); end
      checks++; if (obs_unstable !== 0) begin errors++; $display("FAIL bp_stable got=%0d want=0", obs_unstable); end
      checks++; if (obs_starts !== 1 || {obs_a, obs_b} !== 32'h3C004000) begin errors++; $display("FAIL bp_issue got=%0d %h want=1 3c004000", obs_starts, {obs_a, obs_b}); end
    end
  endtask

  task automatic test_reset_mid();
    do_cmd(8'h01, 16'h1111, 16'h2222, -1, 0, 16'h0, 5'h0, 0, 0, 6);
    #1;
    checks++; if ({busy, out_valid, in_ready} !== 3'b001) begin errors++; $display("FAIL rst_wait got=%b want=001", {busy, out_valid, in_ready}); end
    @(negedge clk); reset = 1'b0;
    do_cmd(8'h01, 16'h1111, 16'h2222, 1, 0, 16'h7777, 5'h04, 0, 5, 6);
    #1;
    checks++; if (obs_lat !== 4) begin errors++; $display("FAIL rst_send_reached got=%0d want=4", obs_lat); end
    checks++; if ({busy, out_valid, in_ready} !== 3'b001) begin errors++; $display("FAIL rst_send got=%b want=001", {busy, out_valid, in_ready}); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++; if ({busy, out_valid, in_ready} !== 3'b001) begin errors++; $display("FAIL rst_release got=%b want=001", {busy, out_valid, in_ready}); end
    do_cmd(8'h04, 16'h4400, 16'h0000, 5, 0, 16'h4000, 5'h00, 1, 1, -1);
    checks++; if (obs_word !== 24'h004000) begin errors++; $display("FAIL rst_fresh got=%h want=004000", obs_word); end
  endtask

  task automatic test_opcode_mask();
    do_cmd(8'hF9, 16'h3C00, 16'h3C00, 4, 1, 16'h3C00, 5'h01, 0, 0, -1);
    checks++; if (obs_op !== 3'd1) begin errors++; $display("FAIL opc_mask got=%0d want=1", obs_op); end
    checks++; if (obs_word !== 24'h013C00) begin errors++; $display("FAIL opc_issue_done got=%h want=013c00", obs_word); end
    checks++; if (obs_lat !== model_lat(4)) begin errors++; $display("FAIL opc_latency got=%0d want=%0d", obs_lat, model_lat(4)); end
  endtask

  task automatic test_random();
    logic [7:0] opb; logic [15:0] a, b, res; logic [4:0] flg; int d;
    for (int n = 0; n < 8; n++) begin
      opb = 8'($urandom); a = 16'($urandom); b = 16'($urandom);
      res = 16'($urandom); flg = 5'($urandom);
      d = (n == 5) ? -1 : int'($urandom_range(20, 0));
      do_cmd(opb, a, b, d, 1'($urandom), res, flg, 2, int'($urandom_range(3, 0)), -1);
      checks++; if (obs_word !== model_bytes(d, res, flg)) begin errors++; $display("FAIL rand_bytes n=%0d got=%h want=%h", n, obs_word, model_bytes(d, res, flg)); end
      checks++; if ({obs_op, obs_a, obs_b} !== {opb[OPC_W-1:0], a, b}) begin errors++; $display("FAIL rand_issue n=%0d got=%h want=%h", n, {obs_op, obs_a, obs_b}, {opb[OPC_W-1:0], a, b}); end
      checks++; if (obs_lat !== model_lat(d) || obs_starts !== 1) begin errors++; $display("FAIL rand_timing n=%0d got=%0d/%0d want=%0d/1", n, obs_lat, obs_starts, model_lat(d)); end
      checks++; if (obs_unstable !== 0 || obs_busy_after !== 1'b0) begin errors++; $display("FAIL rand_stream n=%0d got=%0d/%b want=0/0", n, obs_unstable, obs_busy_after); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_late_done();
    test_backpressure();
    test_reset_mid();
    test_opcode_mask();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
